// File: rtl/grn_attractor_sched_if.sv
// Result channel from the attractor sequencer to the host-side result FIFO.
// The master presents a result with res_valid; the slave accepts it with res_ready.
interface grn_attractor_sched_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_init;
  logic [CW-1:0] res_transient;
  logic [CW-1:0] res_period;
  logic          res_timeout;

  modport master (
    output res_valid, res_init, res_transient, res_period, res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_init, res_transient, res_period, res_timeout,
    output res_ready
  );
endinterface

// File: rtl/grn_attractor_sched.sv
// Sweeps all 2^W initial states of a Boolean node bank, finds each attractor
// with Floyd tortoise/hare stepping, and reports transient length and period.
module grn_attractor_sched #(
  parameter int          W         = 8,
  parameter int          CW        = 16,
  parameter int unsigned MAX_STEPS = 'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 reset_nos,
  output logic [W-1:0]         init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [W-1:0]         s0,
  input  logic [W-1:0]         s1,
  grn_attractor_sched_if.master res,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] F_ISSUE = 3'd2;
  localparam logic [2:0] F_CHECK = 3'd3;
  localparam logic [2:0] P_ISSUE = 3'd4;
  localparam logic [2:0] P_CHECK = 3'd5;
  localparam logic [2:0] EMIT    = 3'd6;

  localparam logic [CW-1:0] MAX_C     = CW'(MAX_STEPS);
  localparam logic [W-1:0]  LAST_INIT = {W{1'b1}};

  logic [2:0]    state;
  logic [W-1:0]  init_cnt;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] per_cnt;

  // Every output is a register, so each branch sets the outputs belonging to
  // the state it is about to enter rather than the state it is leaving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      init_cnt          <= '0;
      step_cnt          <= '0;
      per_cnt           <= '0;
      reset_nos         <= 1'b0;
      init_state        <= '0;
      start_s0          <= 1'b0;
      start_s1          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      res.res_valid     <= 1'b0;
      res.res_init      <= '0;
      res.res_transient <= '0;
      res.res_period    <= '0;
      res.res_timeout   <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are raised only by the branch that
      // enters a strobing state; non-blocking assignment lets the later
      // assignment in the same block win without creating a race.
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            init_cnt   <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            reset_nos  <= 1'b1;
            init_state <= '0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          step_cnt <= '0;
          per_cnt  <= '0;
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= F_ISSUE;
        end

        F_ISSUE: begin
          step_cnt <= step_cnt + 1'b1;
          state    <= F_CHECK;
        end

        F_CHECK: begin
          if (s0 == s1) begin
            start_s1 <= 1'b1;
            state    <= P_ISSUE;
          end else if (step_cnt == MAX_C) begin
            res.res_valid     <= 1'b1;
            res.res_init      <= init_cnt;
            res.res_transient <= step_cnt;
            res.res_period    <= '0;
            res.res_timeout   <= 1'b1;
            state             <= EMIT;
          end else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            state    <= F_ISSUE;
          end
        end

        P_ISSUE: begin
          per_cnt <= per_cnt + 1'b1;
          state   <= P_CHECK;
        end

        // Tortoise is parked on the cycle; the hare walks it once round.
        P_CHECK: begin
          if (s1 == s0) begin
            res.res_valid     <= 1'b1;
            res.res_init      <= init_cnt;
            res.res_transient <= step_cnt;
            res.res_period    <= per_cnt;
            res.res_timeout   <= 1'b0;
            state             <= EMIT;
          end else if (per_cnt == MAX_C) begin
            res.res_valid     <= 1'b1;
            res.res_init      <= init_cnt;
            res.res_transient <= step_cnt;
            res.res_period    <= '0;
            res.res_timeout   <= 1'b1;
            state             <= EMIT;
          end else begin
            start_s1 <= 1'b1;
            state    <= P_ISSUE;
          end
        end

        EMIT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (init_cnt == LAST_INIT) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              init_cnt   <= init_cnt + 1'b1;
              init_state <= init_cnt + 1'b1;
              reset_nos  <= 1'b1;
              state      <= LOAD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grn_attractor_sched.sv
// Directed bench for grn_attractor_sched with W=2 and a behavioural node bank
// whose network is switchable: identity, 2-bit counter, never-meet, never-return.
module tb_grn_attractor_sched;
  localparam int W  = 2;
  localparam int CW = 16;
  localparam int MS = 5;

  typedef struct packed {
    logic [W-1:0]  init;
    logic [CW-1:0] tr;
    logic [CW-1:0] per;
    logic          to;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          reset_nos;
  logic [W-1:0]  init_state;
  logic          start_s0;
  logic          start_s1;
  logic [W-1:0]  s0;
  logic [W-1:0]  s1;
  logic          busy;
  logic          done;

  grn_attractor_sched_if #(.W(W), .CW(CW)) res_if ();

  grn_attractor_sched #(.W(W), .CW(CW), .MAX_STEPS(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .s0         (s0),
    .s1         (s1),
    .res        (res_if.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Node bank model. mode 0: identity, 1: 2-bit counter, 2: hare never meets
  // tortoise, 3: meets at once but the hare never returns during period search.
  // A Floyd step moves the tortoise one transition and the hare two.
  int           mode;
  logic [W-1:0] t_q;
  logic [W-1:0] h_q;
  logic         pphase;

  function automatic logic [W-1:0] f(input logic [W-1:0] x);
    return (mode == 1) ? x + 2'd1 : x;
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      t_q    <= init_state;
      h_q    <= init_state;
      pphase <= 1'b0;
    end else if (start_s0 && start_s1) begin
      t_q <= f(t_q);
      h_q <= f(f(h_q));
    end else if (start_s1) begin
      h_q    <= f(h_q);
      pphase <= 1'b1;
    end
  end

  assign s0 = t_q;
  assign s1 = (mode == 2 || (mode == 3 && pphase)) ? (h_q ^ 2'b01) : h_q;

  res_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_sweep(input logic [CW-1:0] tr, input logic [CW-1:0] per, input logic to);
    for (int i = 0; i < (1 << W); i++) begin
      sb.push_back('{init: W'(i), tr: tr, per: per, to: to});
    end
  endtask

  // Waits (bounded) for the next result, optionally stalls it for 'hold'
  // cycles, then completes the handshake and checks what follows it.
  task automatic get_result(input string tag, input int hold, input bit last);
    res_t         exp;
    logic [W-1:0] nxt;
    int           n;
    exp = sb.pop_front();
    nxt = exp.init + 2'd1;
    res_if.res_ready = (hold == 0);
    n = 0;
    while (!res_if.res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(res_if.res_valid), 64'd1);
    if (!res_if.res_valid) return;
    for (int c = 0; c < hold; c++) begin
      check({tag, "_stall"},
            {res_if.res_valid, res_if.res_init, res_if.res_transient, res_if.res_period,
             res_if.res_timeout, reset_nos, start_s0, start_s1},
            {1'b1, exp, 3'b000});
      @(negedge clk);
    end
    res_if.res_ready = 1'b1;
    check({tag, "_fields"},
          {res_if.res_init, res_if.res_transient, res_if.res_period, res_if.res_timeout}, exp);
    @(negedge clk);
    res_if.res_ready = 1'b0;
    check({tag, "_drop"}, 64'(res_if.res_valid), 64'd0);
    if (last) check({tag, "_done"}, {busy, done}, 2'b01);
    else      check({tag, "_next_load"}, {reset_nos, init_state, busy}, {1'b1, nxt, 1'b1});
  endtask

  initial begin
    logic [2:0] exp_strb;
    bit         seen;
    int         n;

    rst = 1'b1;
    start = 1'b0;
    res_if.res_ready = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {reset_nos, init_state, start_s0, start_s1, res_if.res_valid, res_if.res_init,
           res_if.res_transient, res_if.res_period, res_if.res_timeout, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done, reset_nos}, 3'b000);

    // Identity network: every state is a fixed point; result 1 is stalled.
    mode = 0;
    push_sweep(16'd1, 16'd1, 1'b0);
    pulse_start();
    check("id_load", {reset_nos, init_state, busy, done}, {1'b1, 2'd0, 1'b1, 1'b0});
    get_result("id0", 0, 1'b0);
    get_result("id1", 10, 1'b0);
    get_result("id2", 0, 1'b0);
    get_result("id3", 0, 1'b1);

    // Counter network, started on the cycle done is high; strobe trace of init 0.
    mode = 1;
    push_sweep(16'd4, 16'd4, 1'b0);
    pulse_start();
    check("cnt_load", {reset_nos, init_state, start_s0, start_s1, done},
          {1'b1, 2'd0, 2'b00, 1'b0});
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 8) exp_strb = (k % 2 == 0) ? 3'b011 : 3'b000;
      else       exp_strb = (k % 2 == 0) ? 3'b001 : 3'b000;
      check($sformatf("cnt_trace%0d", k), {reset_nos, start_s0, start_s1}, exp_strb);
    end
    get_result("cnt0", 0, 1'b0);
    get_result("cnt1", 0, 1'b0);
    get_result("cnt2", 3, 1'b0);
    get_result("cnt3", 0, 1'b1);

    // Never-meeting network: Floyd timeout; extra starts while busy are ignored.
    mode = 2;
    push_sweep(16'(MS), 16'd0, 1'b1);
    pulse_start();
    pulse_start();
    pulse_start();
    get_result("fto0", 0, 1'b0);
    pulse_start();
    get_result("fto1", 0, 1'b0);
    get_result("fto2", 0, 1'b0);
    get_result("fto3", 0, 1'b1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_if.res_valid || reset_nos || busy) seen = 1'b1;
    end
    check("no_extra_results", 64'(seen), 64'd0);

    // Meets at once but never returns: period-phase timeout.
    mode = 3;
    push_sweep(16'd1, 16'd0, 1'b1);
    pulse_start();
    get_result("pto0", 0, 1'b0);
    get_result("pto1", 0, 1'b0);
    get_result("pto2", 0, 1'b0);
    get_result("pto3", 0, 1'b1);

    // Abort in P_ISSUE, then a fresh sweep restarts at init 0.
    mode = 1;
    pulse_start();
    n = 0;
    while (!(start_s1 && !start_s0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_p_issue", {start_s0, start_s1}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs",
          {reset_nos, init_state, start_s0, start_s1, res_if.res_valid, res_if.res_init,
           res_if.res_transient, res_if.res_period, res_if.res_timeout, busy, done}, 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", {busy, reset_nos, res_if.res_valid}, 3'b000);
    push_sweep(16'd4, 16'd4, 1'b0);
    pulse_start();
    check("restart_load", {reset_nos, init_state}, {1'b1, 2'd0});
    get_result("rs0", 0, 1'b0);
    get_result("rs1", 0, 1'b0);
    get_result("rs2", 0, 1'b0);
    get_result("rs3", 0, 1'b1);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
